// File: rtl/float_cmd_seq.sv
// float_cmd_seq: command front-end of the float coprocessor.
// Host commands enter a FIFO; a sequencer FSM drains them one at a time,
// serving LOAD/READ directly and routing ADD/SUB through the external
// add/sub stage. The result is then written back to the 8-entry register file.
module float_cmd_seq #(
  parameter int NM    = 23,
  parameter int NE    = 8,
  parameter int NF    = 1 + NE + NM,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [2:0]    cmd_dst,
  input  logic [2:0]    cmd_srca,
  input  logic [2:0]    cmd_srcb,
  input  logic [NF-1:0] cmd_imm,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic          alu_sub,
  output logic [NF-1:0] alu_a,
  output logic [NF-1:0] alu_b,
  input  logic          res_valid,
  input  logic [NF-1:0] res_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NF-1:0] out_data,
  output logic          busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef struct packed {
    logic [1:0]    op;
    logic [2:0]    dst;
    logic [2:0]    srca;
    logic [2:0]    srcb;
    logic [NF-1:0] imm;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_WB, S_OUT
  } state_t;

  cmd_t          fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  state_t        state;
  cmd_t          cmd_q;
  logic [NF-1:0] res_q;
  logic [NF-1:0] rf [8];

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  // A full FIFO refuses pushes even when the sequencer pops in the same cycle.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;
  assign busy      = (state != S_IDLE) || !empty;

  // Command FIFO: storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{op: cmd_op, dst: cmd_dst, srca: cmd_srca,
                              srcb: cmd_srcb, imm: cmd_imm};
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: one command at a time, register file and registered outputs.
  // Writes land before the next DECODE, so later reads always see them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      res_q     <= '0;
      alu_valid <= 1'b0;
      alu_sub   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cmd_q <= fifo_mem[rd_ptr];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (cmd_q.op)
            OP_LOAD: begin
              rf[cmd_q.dst] <= cmd_q.imm;
              state         <= S_IDLE;
            end
            OP_READ: begin
              out_data  <= rf[cmd_q.srca];
              out_valid <= 1'b1;
              state     <= S_OUT;
            end
            default: begin
              alu_a     <= rf[cmd_q.srca];
              alu_b     <= rf[cmd_q.srcb];
              alu_sub   <= (cmd_q.op == OP_SUB);
              alu_valid <= 1'b1;
              state     <= S_ISSUE;
            end
          endcase
        end
        S_ISSUE: begin
          if (alu_ready) begin
            alu_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            res_q <= res_data;
            state <= S_WB;
          end
        end
        S_WB: begin
          rf[cmd_q.dst] <= res_q;
          state         <= S_IDLE;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_cmd_seq.sv
// Bench for float_cmd_seq: directed table, backpressure/reset sequences and
// randomized commands against a register-array reference model.
module tb_float_cmd_seq;
  localparam int NF = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_dst, cmd_srca, cmd_srcb;
  logic [NF-1:0] cmd_imm;
  logic          alu_valid, alu_ready, alu_sub;
  logic [NF-1:0] alu_a, alu_b;
  logic          res_valid;
  logic [NF-1:0] res_data;
  logic          out_valid, out_ready;
  logic [NF-1:0] out_data;
  logic          busy;

  float_cmd_seq #(.NM(23), .NE(8), .NF(NF), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_sub(alu_sub),
    .alu_a(alu_a), .alu_b(alu_b),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: register contents and expected traffic, updated on accept.
  typedef struct { logic [31:0] a; logic [31:0] b; logic sub; } alu_t;
  logic [31:0] mreg [8];
  alu_t        exp_alu [$];
  logic [31:0] exp_out [$];

  int alu_stall = 0, res_lat = 0, out_stall = 0;
  bit spurious  = 0;

  // Stand-in add/sub stage: exact float answers for the documented cases,
  // integer arithmetic otherwise (the DUT only moves bits).
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic sub);
    if (!sub && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if ( sub && a == 32'h40000000 && b == 32'h3F800000) return 32'h3F800000;
    return sub ? a - b : a + b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    exp_alu.delete();
    exp_out.delete();
  endtask

  task automatic push_cmd(input logic [1:0] op, input int dst, input int a, input int b,
                          input logic [31:0] imm, input bit use_exp, input logic [31:0] exp);
    int n = 0;
    cmd_op = op; cmd_dst = 3'(dst); cmd_srca = 3'(a); cmd_srcb = 3'(b); cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("push_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        exp_alu.push_back('{a: mreg[a], b: mreg[b], sub: op[0]});
        mreg[dst] = alu_fn(mreg[a], mreg[b], op[0]);
      end
      2'b10: mreg[dst] = imm;
      default: exp_out.push_back(use_exp ? exp : mreg[a]);
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_out.size() != 0 || exp_alu.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
  endtask

  // Add/sub stage responder: checks operands, stalls, returns a result strobe.
  initial begin : alu_side
    logic [31:0] a0, b0;
    logic        s0;
    alu_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (spurious) begin
        res_valid = 1'b1; res_data = 32'hDEADBEEF; spurious = 0;
      end else if (alu_valid && !reset) begin
        a0 = alu_a; b0 = alu_b; s0 = alu_sub;
        if (exp_alu.size() == 0) chk("alu_unexpected", 32'd1, 32'd0);
        else begin
          chk("alu_a", a0, exp_alu[0].a);
          chk("alu_b", b0, exp_alu[0].b);
          chk("alu_sub", 32'(s0), 32'(exp_alu[0].sub));
          void'(exp_alu.pop_front());
        end
        for (int k = 0; k < alu_stall; k++) begin
          @(negedge clk);
          chk("alu_hold_valid", 32'(alu_valid), 32'd1);
          chk("alu_hold_a", alu_a, a0);
          chk("alu_hold_b", alu_b, b0);
        end
        alu_ready = 1'b1;
        @(negedge clk);
        alu_ready = 1'b0;
        for (int k = 0; k < res_lat; k++) @(negedge clk);
        res_valid = 1'b1;
        res_data  = alu_fn(a0, b0, s0);
      end
    end
  end

  // Host read port: compares READ data, optionally stalls out_ready.
  initial begin : out_side
    logic [31:0] d0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !reset) begin
        d0 = out_data;
        if (exp_out.size() == 0) chk("read_unexpected", 32'd1, 32'd0);
        else chk("read_data", d0, exp_out.pop_front());
        for (int k = 0; k < out_stall; k++) begin
          @(negedge clk);
          chk("out_hold_valid", 32'(out_valid), 32'd1);
          chk("out_hold_data", out_data, d0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    int          dst, a, b;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  initial begin : main
    int n;
    tbl[0] = '{2'b10, 1, 0, 0, 32'h3F800000, 32'h0};
    tbl[1] = '{2'b10, 2, 0, 0, 32'h40000000, 32'h0};
    tbl[2] = '{2'b00, 3, 1, 2, 32'h0,        32'h0};
    tbl[3] = '{2'b11, 0, 3, 0, 32'h0,        32'h40400000};
    tbl[4] = '{2'b01, 4, 2, 1, 32'h0,        32'h0};
    tbl[5] = '{2'b11, 0, 4, 0, 32'h0,        32'h3F800000};
    tbl[6] = '{2'b11, 0, 1, 0, 32'h0,        32'h3F800000};
    tbl[7] = '{2'b00, 1, 1, 1, 32'h0,        32'h0};
    tbl[8] = '{2'b11, 0, 1, 0, 32'h0,        32'h7F000000};

    model_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0;
    cmd_srca = '0; cmd_srcb = '0; cmd_imm = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_alu_a",     alu_a,          32'd0);
    chk("rst_alu_b",     alu_b,          32'd0);
    chk("rst_out_data",  out_data,       32'd0);

    // Directed table: ADD/SUB with 5-cycle ALU stall, READs with 3-cycle stall.
    alu_stall = 5; out_stall = 3; res_lat = 1;
    for (int i = 0; i < 9; i++)
      push_cmd(tbl[i].op, tbl[i].dst, tbl[i].a, tbl[i].b, tbl[i].imm,
               tbl[i].op == 2'b11, tbl[i].exp);
    wait_idle();

    // FIFO fills while the sequencer is stuck in ISSUE; order must survive.
    alu_stall = 40; out_stall = 0; res_lat = 0;
    push_cmd(2'b00, 5, 3, 4, 32'h0, 0, 32'h0);
    n = 0;
    while (!alu_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_alu_valid", 32'(alu_valid), 32'd1);
    push_cmd(2'b10, 5, 0, 0, 32'h11111111, 0, 32'h0);
    push_cmd(2'b11, 0, 5, 0, 32'h0, 1, 32'h11111111);
    push_cmd(2'b10, 5, 0, 0, 32'h22222222, 0, 32'h0);
    push_cmd(2'b11, 0, 5, 0, 32'h0, 1, 32'h22222222);
    chk("bp_cmd_ready_full", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    push_cmd(2'b10, 6, 0, 0, 32'h33333333, 0, 32'h0);
    push_cmd(2'b11, 0, 6, 0, 32'h0, 1, 32'h33333333);
    wait_idle();

    // Stray result strobe while idle must not touch any register.
    alu_stall = 0;
    push_cmd(2'b10, 7, 0, 0, 32'hCAFEF00D, 0, 32'h0);
    wait_idle();
    spurious = 1;
    repeat (3) @(negedge clk);
    push_cmd(2'b11, 0, 7, 0, 32'h0, 1, 32'hCAFEF00D);
    wait_idle();

    // Randomized command stream checked against the model.
    for (int i = 0; i < 80; i++) begin
      logic [1:0] op;
      alu_stall = $urandom_range(0, 3);
      res_lat   = $urandom_range(0, 3);
      out_stall = $urandom_range(0, 2);
      op = 2'($urandom_range(0, 3));
      push_cmd(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom, 0, 32'h0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_idle();

    // Reset while waiting on the add/sub result.
    alu_stall = 0; res_lat = 20;
    push_cmd(2'b00, 0, 1, 2, 32'h0, 0, 32'h0);
    n = 0;
    while (!alu_valid && n < 50) begin @(negedge clk); n++; end
    while (alu_valid && n < 100) begin @(negedge clk); n++; end
    chk("rw_reached_wait", 32'(n < 100), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rw_alu_valid", 32'(alu_valid), 32'd0);
    chk("rw_busy",      32'(busy),      32'd0);
    chk("rw_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
    res_lat = 0;
    push_cmd(2'b11, 0, 1, 0, 32'h0, 1, 32'h00000000);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
